// File: rtl/ula_div_sequencer.sv
// ---------------------------------------------------------------------------
// ula_div_sequencer
//
// Purpose:
//   Multi-cycle unsigned restoring divider controller. It drives the ULA's
//   shared enabled subtractor (sub_a - sub_b -> sub_s, where sub_s[8] is the
//   borrow). It produces one quotient bit per SHIFT/SUB pair, so eight pairs
//   give the full result.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   dividend     numerator, captured at the accepted start edge
//   divisor      denominator, captured at the accepted start edge
//   sub_s        shared subtractor result (combinational, same cycle)
//   sub_a/sub_b  subtractor operands, driven only in SUB, zero otherwise
//   sub_en       subtractor tri-state enable, high only in SUB
//   busy         high while in SHIFT/SUB
//   done         one-cycle completion pulse
//   quotient     result register
//   remainder    result register
//   div_by_zero  set when the last accepted operation had divisor == 0
// ---------------------------------------------------------------------------
module ula_div_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH:0]   sub_s,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH:0]   r_q;      // partial remainder, one extra bit for the shift-out
  logic [WIDTH-1:0] q_q;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_q;      // captured divisor
  logic [3:0]       count_q;  // quotient bits still to produce
  logic             take_d;

  // The bus is released in every state except SUB. These lines depend only
  // on state and registers, so there is no path from inputs to outputs.
  assign sub_en = (state_q == SUB);
  assign sub_a  = sub_en ? r_q[WIDTH-1:0] : '0;
  assign sub_b  = sub_en ? d_q : '0;

  // When R[8] is set, R >= 256 > D, so subtraction is always possible. The
  // true difference is also below D, so the low byte of sub_s is exact even
  // though the 8-bit subtractor reports a borrow.
  assign take_d = r_q[WIDTH] | ~sub_s[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q_q         <= dividend;
              d_q         <= divisor;
              r_q         <= '0;
              count_q     <= 4'(WIDTH);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state_q     <= SHIFT;
            end else begin
              // Divide-by-zero finishes immediately with saturated quotient.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        SHIFT: begin
          r_q     <= {r_q[WIDTH-1:0], q_q[WIDTH-1]};
          q_q     <= {q_q[WIDTH-2:0], 1'b0};
          state_q <= SUB;
        end

        SUB: begin
          if (take_d) begin
            r_q    <= {1'b0, sub_s[WIDTH-1:0]};
            q_q[0] <= 1'b1;
          end
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            // Load results including this last step's take decision.
            quotient  <= {q_q[WIDTH-1:1], take_d};
            remainder <= take_d ? sub_s[WIDTH-1:0] : r_q[WIDTH-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end

        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_div_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for ula_div_sequencer. A behavioural model of the
// shared 8-bit subtractor closes the loop. All expected results are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ula_div_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [8:0] sub_s;
  logic [7:0] sub_a;
  logic [7:0] sub_b;
  logic       sub_en;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int vectors;
  int miscompares;

  ula_div_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .sub_s      (sub_s),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_en     (sub_en),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Shared subtractor model: 9-bit result, bit 8 is the borrow.
  assign sub_s = sub_en ? ({1'b0, sub_a} - {1'b0, sub_b}) : 9'h000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start, then waits (bounded) for done. It checks latency, busy
  // duration, subtractor usage, results, and that done lasts one cycle.
  task automatic run_div(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                         input logic [7:0] exp_q, input logic [7:0] exp_r,
                         input logic exp_dz, input int exp_lat, input int exp_subs);
    int cyc;
    int subs;
    int busy_cycles;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();                 // edge 0
    start    = 1'b0;
    cyc = 0; subs = 0; busy_cycles = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cycles++;
      if (sub_en === 1'b1) subs++;
      tick();
      cyc++;
    end
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
    chk({tag, " sub_en_cycles"}, 32'(subs), 32'(exp_subs));
    chk({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    chk({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dz));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " bus_released"}, 32'({sub_en, sub_a, sub_b}), 32'd0);
    tick();
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    $display("div %0d/%0d -> q=%0d r=%0d dz=%0d latency=%0d", dd, dv, quotient, remainder, div_by_zero, cyc);
  endtask

  initial begin
    int cyc;
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;

    // Reset state
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset results", 32'({quotient, remainder}), 32'd0);
    chk("reset dz", 32'(div_by_zero), 32'd0);
    chk("reset bus", 32'({sub_en, sub_a, sub_b}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Main function and boundaries
    run_div("100/7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 16, 8);
    run_div("255/128", 8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 16, 8);
    run_div("255/1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 16, 8);
    run_div("200/250", 8'd200, 8'd250, 8'd0,   8'd200, 1'b0, 16, 8);
    run_div("77/0",    8'd77,  8'd0,   8'hFF,  8'd77,  1'b1, 0,  0);

    // Results and flag hold while idle
    tick();
    tick();
    chk("hold quotient", 32'(quotient), 32'hFF);
    chk("hold dz", 32'(div_by_zero), 32'd1);

    // Start while busy is ignored; start during DONE is ignored too
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();                 // edge 0
    start    = 1'b0;
    chk("accept dz cleared", 32'(div_by_zero), 32'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 5) begin
        dividend = 8'd9;
        divisor  = 8'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("ignored-start latency", 32'(cyc), 32'd16);
    chk("ignored-start result", 32'({quotient, remainder}), 32'({8'd14, 8'd2}));
    start = 1'b1;           // present during DONE
    tick();
    start = 1'b0;
    chk("start in DONE ignored", 32'(busy), 32'd0);
    tick();
    chk("start in DONE no effect", 32'({busy, done}), 32'd0);
    $display("ignored starts -> q=%0d r=%0d", quotient, remainder);

    run_div("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 16, 8);

    // Reset in the middle of an operation
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();                 // edge 0
    start    = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre-reset in SUB", 32'(sub_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy/done", 32'({busy, done}), 32'd0);
    chk("async reset results", 32'({quotient, remainder}), 32'd0);
    chk("async reset bus", 32'({sub_en, sub_a, sub_b}), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    chk("no done after abort", 32'(done_seen), 32'd0);
    $display("reset mid-op -> busy=%0d q=%0d r=%0d", busy, quotient, remainder);

    run_div("50/5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 16, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
